aq_ifu_ras_stack: RTL and testbench
===================================

// Module: aq_ifu_ras_stack
// PURPOSE
//  Return-address-stack controller and read side for IFU branch prediction. Consumes call (push) and
//  return (pop) predictions from the IFU predecode stage. Owns the entry array and presents the
//  top-of-stack PC as the predicted return target.
//  Keeps a retire-side pointer copy, updated from RTU, so an IFU flush restores the stack depth.
// PARAMETERS
//  DEPTH   6   number of stack entries (>=2)
//  PC_W    24  stored return-PC width (PC[PC_W:1])
//  PTR_W   3   pointer width, clog2(DEPTH)
// PORTS
//  forever_cpuclk    in   1      clock
//  cpurst            in   1      synchronous reset, active-high
//  ifu_ras_push_vld  in   1      predicted call: push ifu_ras_push_pc
//  ifu_ras_push_pc   in   PC_W   return address to push
//  ifu_ras_pop_vld   in   1      predicted return: pop top
//  rtu_ras_push_vld  in   1      retired call
//  rtu_ras_pop_vld   in   1      retired return
//  ifu_ras_flush     in   1      mispredict/flush: restore speculative pointer from retire copy
//  ras_ifu_top_vld   out  1      stack non-empty; top PC usable as prediction
//  ras_ifu_top_pc    out  PC_W   entry[spec_ptr]
//  ras_ifu_full      out  1      spec_cnt == DEPTH
//  ras_ifu_empty     out  1      spec_cnt == 0
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-high.
//  State: entry[DEPTH] x PC_W; spec_ptr/spec_cnt; rtu_ptr/rtu_cnt. ptr = index of top; cnt in 0..DEPTH.
//  Reset (cpurst=1 at posedge): all ptrs=0, cnts=0, entries=0.
//    Outputs after reset: top_vld=0, top_pc=0, empty=1, full=0. Reset overrides all other inputs.
//  Outputs are combinational from registers only. An update at edge N is visible after edge N
//    (push-to-read latency 1 cycle).
//  Push only: ptr<=ptr+1 mod DEPTH (DEPTH-1 wraps to 0); entry[ptr+1]<=push_pc; cnt<=min(cnt+1,DEPTH).
//    When full, the push overwrites the oldest entry (circular). Full is not an error.
//  Pop only: if cnt>0 then ptr<=ptr-1 mod DEPTH (0 wraps to DEPTH-1) and cnt<=cnt-1.
//    If cnt==0 the pop is ignored: no change, no underflow.
//  Push+pop same cycle (return then call): entry[ptr]<=push_pc; ptr and cnt unchanged.
//    If cnt==0, behaves as push only.
//  Retire pointer pair: same push/pop/both rules driven by rtu_ras_*; never writes entries.
//  Flush: spec_ptr<=rtu_ptr, spec_cnt<=rtu_cnt, using the rtu values after this cycle's rtu update.
//    Flush overrides same-cycle ifu push/pop; entries are not rolled back.
//    Stale entry contents after flush are accepted prediction error.
//  Pointer arithmetic is explicit modular compare-and-wrap; it must not rely on power-of-two DEPTH.
//  cnt width is PTR_W+1 when DEPTH is a power of two.
// STRUCTURE
//  Shared package (aq_ifu_pkg): RAS_DEPTH, RAS_PC_W, RAS_PTR_W constants; ptr_inc/ptr_dec wrap functions.
//  Sub-module aq_ifu_ras_ptr: ptr+cnt register pair with push/pop/both/restore logic.
//    Instantiated twice: speculative (with restore) and retire (restore tied 0).
//  Top level: entry array with write decode from the spec ptr, DEPTH:1 read mux, flag logic.
// TESTING
//  1 Reset mid-operation: push 3 then cpurst=1 for 1 cycle -> empty=1, top_vld=0, top_pc=0; a following pop is ignored.
//  2 Push 0x000100, 0x000200, 0x000300 -> top_pc=0x000300, cnt 3.
//    Then 3 pops -> top 0x000200, 0x000100, then empty=1; a 4th pop leaves ptr unchanged.
//  3 Overflow: push 0x10..0x16 (7 pushes, DEPTH=6) -> full=1, top=0x16.
//    Then 6 pops read 0x16,0x15,0x14,0x13,0x12,0x11 and empty=1; ptr wraps 5->0.
//  4 Push 0xA then push+pop with 0xB in the same cycle -> top=0xB, cnt stays 1.
//    Push+pop when empty -> cnt=1, top=push_pc.
//  5 Flush: rtu push x2, ifu push x4 -> cnt 4; ifu_ras_flush -> cnt 2, top = entry at rtu_ptr.
//    Flush together with ifu push and rtu pop -> spec = post-pop rtu state (cnt 1); push dropped.
//  6 Random push/pop/flush versus a reference queue model; check top_pc/top_vld/full/empty every cycle.

Source files
------------

// File: rtl/aq_ifu_pkg.sv
// Shared IFU constants and modular pointer helpers for the return address stack.
package aq_ifu_pkg;

    localparam int RAS_DEPTH = 6;
    localparam int RAS_PC_W  = 24;
    localparam int RAS_PTR_W = 3;
    localparam int RAS_CNT_W = $clog2(RAS_DEPTH + 1);

    // Compare-and-wrap so non-power-of-two depths wrap correctly.
    function automatic int ptr_inc(input int ptr, input int depth);
        return (ptr >= depth - 1) ? 0 : ptr + 1;
    endfunction

    function automatic int ptr_dec(input int ptr, input int depth);
        return (ptr == 0) ? depth - 1 : ptr - 1;
    endfunction

endpackage

// File: rtl/aq_ifu_ras_ptr.sv
// Top-of-stack pointer and occupancy counter with push/pop/replace/restore update rules.
module aq_ifu_ras_ptr
    import aq_ifu_pkg::*;
#(
    parameter int DEPTH = RAS_DEPTH,
    parameter int PTR_W = RAS_PTR_W,
    parameter int CNT_W = RAS_CNT_W
) (
    input  logic             forever_cpuclk,
    input  logic             cpurst,
    input  logic             push_vld,
    input  logic             pop_vld,
    input  logic             restore_vld,
    input  logic [PTR_W-1:0] restore_ptr,
    input  logic [CNT_W-1:0] restore_cnt,
    output logic [PTR_W-1:0] ptr,
    output logic [CNT_W-1:0] cnt,
    output logic [PTR_W-1:0] ptr_nxt,
    output logic [CNT_W-1:0] cnt_nxt
);

    logic cnt_zero;
    logic cnt_full;

    assign cnt_zero = (cnt == '0);
    assign cnt_full = (cnt == CNT_W'(DEPTH));

    always_comb begin
        ptr_nxt = ptr;
        cnt_nxt = cnt;
        if (restore_vld) begin
            ptr_nxt = restore_ptr;
            cnt_nxt = restore_cnt;
        end else if (push_vld && pop_vld && !cnt_zero) begin
            // Return-then-call replaces the top in place; depth is unchanged.
            ptr_nxt = ptr;
            cnt_nxt = cnt;
        end else if (push_vld) begin
            ptr_nxt = PTR_W'(ptr_inc(int'(ptr), DEPTH));
            cnt_nxt = cnt_full ? cnt : cnt + CNT_W'(1);
        end else if (pop_vld && !cnt_zero) begin
            ptr_nxt = PTR_W'(ptr_dec(int'(ptr), DEPTH));
            cnt_nxt = cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            ptr <= '0;
            cnt <= '0;
        end else begin
            ptr <= ptr_nxt;
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/aq_ifu_ras_stack.sv
// Return address stack: entry array, speculative and retire pointer pairs, top-of-stack read.
module aq_ifu_ras_stack
    import aq_ifu_pkg::*;
#(
    parameter int DEPTH = RAS_DEPTH,
    parameter int PC_W  = RAS_PC_W,
    parameter int PTR_W = RAS_PTR_W
) (
    input  logic            forever_cpuclk,
    input  logic            cpurst,
    input  logic            ifu_ras_push_vld,
    input  logic [PC_W-1:0] ifu_ras_push_pc,
    input  logic            ifu_ras_pop_vld,
    input  logic            rtu_ras_push_vld,
    input  logic            rtu_ras_pop_vld,
    input  logic            ifu_ras_flush,
    output logic            ras_ifu_top_vld,
    output logic [PC_W-1:0] ras_ifu_top_pc,
    output logic            ras_ifu_full,
    output logic            ras_ifu_empty
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PC_W-1:0]  entry_q [DEPTH];
    logic [PTR_W-1:0] spec_ptr;
    logic [CNT_W-1:0] spec_cnt;
    logic [PTR_W-1:0] spec_ptr_nxt;
    logic [CNT_W-1:0] spec_cnt_nxt;
    logic [PTR_W-1:0] rtu_ptr;
    logic [CNT_W-1:0] rtu_cnt;
    logic [PTR_W-1:0] rtu_ptr_nxt;
    logic [CNT_W-1:0] rtu_cnt_nxt;
    logic             ifu_wr_en;
    logic [PTR_W-1:0] ifu_wr_idx;
    logic             ptr_unused;

    aq_ifu_ras_ptr #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .CNT_W (CNT_W)
    ) u_rtu_ptr (
        .forever_cpuclk (forever_cpuclk),
        .cpurst         (cpurst),
        .push_vld       (rtu_ras_push_vld),
        .pop_vld        (rtu_ras_pop_vld),
        .restore_vld    (1'b0),
        .restore_ptr    ('0),
        .restore_cnt    ('0),
        .ptr            (rtu_ptr),
        .cnt            (rtu_cnt),
        .ptr_nxt        (rtu_ptr_nxt),
        .cnt_nxt        (rtu_cnt_nxt)
    );

    // Flush restores from the retire pair as it will be after this edge.
    aq_ifu_ras_ptr #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .CNT_W (CNT_W)
    ) u_spec_ptr (
        .forever_cpuclk (forever_cpuclk),
        .cpurst         (cpurst),
        .push_vld       (ifu_ras_push_vld),
        .pop_vld        (ifu_ras_pop_vld),
        .restore_vld    (ifu_ras_flush),
        .restore_ptr    (rtu_ptr_nxt),
        .restore_cnt    (rtu_cnt_nxt),
        .ptr            (spec_ptr),
        .cnt            (spec_cnt),
        .ptr_nxt        (spec_ptr_nxt),
        .cnt_nxt        (spec_cnt_nxt)
    );

    assign ptr_unused = ^{spec_ptr_nxt, spec_cnt_nxt, rtu_ptr, rtu_cnt};

    // A push dropped by flush must not write either.
    assign ifu_wr_en  = ifu_ras_push_vld && !ifu_ras_flush;
    assign ifu_wr_idx = (ifu_ras_pop_vld && (spec_cnt != '0))
                      ? spec_ptr
                      : PTR_W'(ptr_inc(int'(spec_ptr), DEPTH));

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else if (ifu_wr_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ifu_wr_idx == PTR_W'(i)) begin
                    entry_q[i] <= ifu_ras_push_pc;
                end
            end
        end
    end

    always_comb begin
        ras_ifu_top_pc = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (spec_ptr == PTR_W'(i)) begin
                ras_ifu_top_pc = entry_q[i];
            end
        end
    end

    assign ras_ifu_empty   = (spec_cnt == '0);
    assign ras_ifu_full    = (spec_cnt == CNT_W'(DEPTH));
    assign ras_ifu_top_vld = !ras_ifu_empty;

endmodule

// File: tb/tb_aq_ifu_ras_stack.sv
// Bench for aq_ifu_ras_stack: directed vector table, hand sequences and a random run against a model.
module tb_aq_ifu_ras_stack;

    localparam int D = 6;

    logic        forever_cpuclk;
    logic        cpurst;
    logic        ifu_ras_push_vld;
    logic [23:0] ifu_ras_push_pc;
    logic        ifu_ras_pop_vld;
    logic        rtu_ras_push_vld;
    logic        rtu_ras_pop_vld;
    logic        ifu_ras_flush;
    logic        ras_ifu_top_vld;
    logic [23:0] ras_ifu_top_pc;
    logic        ras_ifu_full;
    logic        ras_ifu_empty;

    int chk_cnt = 0;
    int err_cnt = 0;

    // Reference state: plain integers, modulo arithmetic.
    int m_sp, m_sc, m_rp, m_rc;
    int m_ent [D];

    typedef struct {
        logic        rst;
        logic        push;
        logic [23:0] pc;
        logic        pop;
        logic        rpush;
        logic        rpop;
        logic        flush;
        logic        e_vld;
        logic [23:0] e_pc;
        logic        e_full;
        logic        e_empty;
    } vec_t;

    vec_t vecs[$];

    aq_ifu_ras_stack dut (
        .forever_cpuclk   (forever_cpuclk),
        .cpurst           (cpurst),
        .ifu_ras_push_vld (ifu_ras_push_vld),
        .ifu_ras_push_pc  (ifu_ras_push_pc),
        .ifu_ras_pop_vld  (ifu_ras_pop_vld),
        .rtu_ras_push_vld (rtu_ras_push_vld),
        .rtu_ras_pop_vld  (rtu_ras_pop_vld),
        .ifu_ras_flush    (ifu_ras_flush),
        .ras_ifu_top_vld  (ras_ifu_top_vld),
        .ras_ifu_top_pc   (ras_ifu_top_pc),
        .ras_ifu_full     (ras_ifu_full),
        .ras_ifu_empty    (ras_ifu_empty)
    );

    initial forever_cpuclk = 1'b0;
    always #5 forever_cpuclk = ~forever_cpuclk;

    task automatic add(input logic rst, push, input logic [23:0] pc, input logic pop, rpush, rpop, flush,
                       input logic e_vld, input logic [23:0] e_pc, input logic e_full, e_empty);
        vec_t v;
        v.rst = rst; v.push = push; v.pc = pc; v.pop = pop;
        v.rpush = rpush; v.rpop = rpop; v.flush = flush;
        v.e_vld = e_vld; v.e_pc = e_pc; v.e_full = e_full; v.e_empty = e_empty;
        vecs.push_back(v);
    endtask

    task automatic mdl_ptr(input logic push, pop, input int p_i, c_i, output int p_o, c_o);
        p_o = p_i;
        c_o = c_i;
        if (push && pop && c_i > 0) begin
            p_o = p_i;
        end else if (push) begin
            p_o = (p_i + 1) % D;
            c_o = (c_i < D) ? c_i + 1 : D;
        end else if (pop && c_i > 0) begin
            p_o = (p_i + D - 1) % D;
            c_o = c_i - 1;
        end
    endtask

    task automatic mdl_update(input logic rst, push, input logic [23:0] pc, input logic pop, rpush, rpop, flush);
        int np, nc;
        if (rst) begin
            m_sp = 0; m_sc = 0; m_rp = 0; m_rc = 0;
            for (int i = 0; i < D; i++) m_ent[i] = 0;
        end else begin
            if (push && !flush) begin
                if (pop && m_sc > 0) m_ent[m_sp] = int'(pc);
                else                 m_ent[(m_sp + 1) % D] = int'(pc);
            end
            mdl_ptr(rpush, rpop, m_rp, m_rc, np, nc);
            m_rp = np; m_rc = nc;
            if (flush) begin
                m_sp = m_rp; m_sc = m_rc;
            end else begin
                mdl_ptr(push, pop, m_sp, m_sc, np, nc);
                m_sp = np; m_sc = nc;
            end
        end
    endtask

    task automatic step(input logic rst, push, input logic [23:0] pc, input logic pop, rpush, rpop, flush);
        cpurst           = rst;
        ifu_ras_push_vld = push;
        ifu_ras_push_pc  = pc;
        ifu_ras_pop_vld  = pop;
        rtu_ras_push_vld = rpush;
        rtu_ras_pop_vld  = rpop;
        ifu_ras_flush    = flush;
        mdl_update(rst, push, pc, pop, rpush, rpop, flush);
        @(posedge forever_cpuclk);
        #1;
    endtask

    task automatic check(input string name, input logic e_vld, input logic [23:0] e_pc, input logic e_full, e_empty);
        chk_cnt += 4;
        if (ras_ifu_top_vld !== e_vld) begin
            err_cnt++;
            $display("FAIL %s top_vld: got %0b want %0b", name, ras_ifu_top_vld, e_vld);
        end
        if (ras_ifu_top_pc !== e_pc) begin
            err_cnt++;
            $display("FAIL %s top_pc: got %06h want %06h", name, ras_ifu_top_pc, e_pc);
        end
        if (ras_ifu_full !== e_full) begin
            err_cnt++;
            $display("FAIL %s full: got %0b want %0b", name, ras_ifu_full, e_full);
        end
        if (ras_ifu_empty !== e_empty) begin
            err_cnt++;
            $display("FAIL %s empty: got %0b want %0b", name, ras_ifu_empty, e_empty);
        end
    endtask

    initial begin
        cpurst = 1'b1; ifu_ras_push_vld = 1'b0; ifu_ras_push_pc = '0; ifu_ras_pop_vld = 1'b0;
        rtu_ras_push_vld = 1'b0; rtu_ras_pop_vld = 1'b0; ifu_ras_flush = 1'b0;

        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        check("reset", 0, 24'h0, 0, 1);

        // Reset in the middle of activity, with a push asserted alongside it.
        step(0, 1, 24'h000111, 0, 0, 0, 0);
        step(0, 1, 24'h000222, 0, 0, 0, 0);
        step(0, 1, 24'h000333, 0, 0, 0, 0);
        check("pre_rst_top", 1, 24'h000333, 0, 0);
        step(1, 1, 24'h000444, 0, 0, 0, 0);
        check("mid_rst", 0, 24'h0, 0, 1);
        step(0, 0, 0, 1, 0, 0, 0);
        check("pop_after_rst", 0, 24'h0, 0, 1);
        step(0, 1, 24'h000555, 0, 0, 0, 0);
        check("push_after_rst", 1, 24'h000555, 0, 0);

        // Basic push/pop and underflow.
        add(1, 0, 0, 0, 0, 0, 0,               0, 24'h0, 0, 1);
        add(0, 1, 24'h000100, 0, 0, 0, 0,      1, 24'h000100, 0, 0);
        add(0, 1, 24'h000200, 0, 0, 0, 0,      1, 24'h000200, 0, 0);
        add(0, 1, 24'h000300, 0, 0, 0, 0,      1, 24'h000300, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0,               1, 24'h000200, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0,               1, 24'h000100, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0,               0, 24'h0, 0, 1);
        add(0, 0, 0, 1, 0, 0, 0,               0, 24'h0, 0, 1);
        add(0, 1, 24'h000400, 0, 0, 0, 0,      1, 24'h000400, 0, 0);
        // Overflow wraps and overwrites the oldest entry.
        add(1, 0, 0, 0, 0, 0, 0,               0, 24'h0, 0, 1);
        for (int k = 0; k < 7; k++)
            add(0, 1, 24'(16 + k), 0, 0, 0, 0, 1, 24'(16 + k), (k >= 5), 0);
        for (int k = 0; k < 5; k++)
            add(0, 0, 0, 1, 0, 0, 0,           1, 24'(21 - k), 0, 0);
        add(0, 0, 0, 1, 0, 0, 0,               0, 24'h000016, 0, 1);
        // Push+pop replaces the top; on an empty stack it acts as a push.
        add(1, 0, 0, 0, 0, 0, 0,               0, 24'h0, 0, 1);
        add(0, 1, 24'h00000A, 0, 0, 0, 0,      1, 24'h00000A, 0, 0);
        add(0, 1, 24'h00000B, 1, 0, 0, 0,      1, 24'h00000B, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0,               0, 24'h0, 0, 1);
        add(0, 1, 24'h00000C, 1, 0, 0, 0,      1, 24'h00000C, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0,               0, 24'h0, 0, 1);
        // Flush restores from the retire pair, including a same-cycle retire pop.
        add(1, 0, 0, 0, 0, 0, 0,               0, 24'h0, 0, 1);
        add(0, 0, 0, 0, 1, 0, 0,               0, 24'h0, 0, 1);
        add(0, 0, 0, 0, 1, 0, 0,               0, 24'h0, 0, 1);
        add(0, 1, 24'h0000A1, 0, 0, 0, 0,      1, 24'h0000A1, 0, 0);
        add(0, 1, 24'h0000A2, 0, 0, 0, 0,      1, 24'h0000A2, 0, 0);
        add(0, 1, 24'h0000A3, 0, 0, 0, 0,      1, 24'h0000A3, 0, 0);
        add(0, 1, 24'h0000A4, 0, 0, 0, 0,      1, 24'h0000A4, 0, 0);
        add(0, 0, 0, 0, 0, 0, 1,               1, 24'h0000A2, 0, 0);
        add(0, 1, 24'h0000EE, 0, 0, 1, 1,      1, 24'h0000A1, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0,               0, 24'h0, 0, 1);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].push, vecs[i].pc, vecs[i].pop,
                 vecs[i].rpush, vecs[i].rpop, vecs[i].flush);
            check($sformatf("vec%0d", i), vecs[i].e_vld, vecs[i].e_pc, vecs[i].e_full, vecs[i].e_empty);
        end

        step(1, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 4000; n++) begin
            logic r_rst, r_push, r_pop, r_rpush, r_rpop, r_flush;
            logic [23:0] r_pc;
            r_rst   = ($urandom_range(0, 199) == 0);
            r_push  = ($urandom_range(0, 99) < 45);
            r_pop   = ($urandom_range(0, 99) < 35);
            r_rpush = ($urandom_range(0, 3) == 0);
            r_rpop  = ($urandom_range(0, 3) == 0);
            r_flush = ($urandom_range(0, 15) == 0);
            r_pc    = 24'($urandom);
            step(r_rst, r_push, r_pc, r_pop, r_rpush, r_rpop, r_flush);
            check($sformatf("rand%0d", n), (m_sc > 0), 24'(m_ent[m_sp]), (m_sc == D), (m_sc == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule
